// File: rtl/char_plane_wr_pkg.sv
// Shared constants, FSM state type and the optional chroma-key pixel map
// for the character/OSD plane writer.
package char_plane_wr_pkg;

  localparam int unsigned DEF_MEM_DQ_WIDTH   = 32;
  localparam int unsigned DEF_PIX_WIDTH      = 16;
  localparam int unsigned DEF_AXI_ADDR_WIDTH = 28;
  localparam int unsigned DEF_LEN_WIDTH      = 32;

  localparam logic [DEF_PIX_WIDTH-1:0] KEY_COLOR = 16'hF81F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_WAIT
  } wr_state_e;

  // Key colour becomes transparent; genuine black is nudged to 1 so it stays opaque.
  function automatic logic [DEF_PIX_WIDTH-1:0] key_map(input logic [DEF_PIX_WIDTH-1:0] pix);
    if (pix == KEY_COLOR)
      return '0;
    else if (pix == '0)
      return DEF_PIX_WIDTH'(1);
    else
      return pix;
  endfunction

endpackage

// File: rtl/char_wbuf_fifo.sv
// Single-clock word buffer between the pixel packer and the DDR burst engine.
// Head word is presented combinationally on dout; level counts stored words.
module char_wbuf_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array, no reset needed on the data itself
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
  assign full = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/char_plane_wr.sv
// Character/OSD plane writer: packs 16-bit pixels into 256-bit words and
// writes them to DDR as fixed-length bursts laid out for the overlay reader.
// Optional feature macro: CHAR_WR_KEY_EN (chroma key to transparent mapping).
module char_plane_wr
  import char_plane_wr_pkg::*;
#(
  parameter int unsigned MEM_DQ_WIDTH   = DEF_MEM_DQ_WIDTH,
  parameter int unsigned PIX_WIDTH      = DEF_PIX_WIDTH,
  parameter int unsigned AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int unsigned BURST_LEN      = 40,
  parameter int unsigned ADDR_STEP      = 320,
  parameter int unsigned FRAME_BEATS    = 57600,
  parameter int unsigned BUF_DEPTH      = 128
) (
  input  logic                      ddr_clk,
  input  logic                      ddr_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] write_BaseDdr_addr,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      pix_sof,
  input  logic [PIX_WIDTH-1:0]      pix_data,
  output logic                      ddr_wreq,
  output logic [AXI_ADDR_WIDTH-1:0] ddr_waddr,
  output logic [LEN_WIDTH-1:0]      ddr_wr_len,
  input  logic                      ddr_wrdy,
  input  logic                      ddr_wdata_req,
  output logic [8*MEM_DQ_WIDTH-1:0] ddr_wdata,
  input  logic                      ddr_wdone,
  output logic                      frame_done,
  output logic                      sof_err
);

  localparam int unsigned WORD_W       = 8 * MEM_DQ_WIDTH;
  localparam int unsigned PIX_PER_WORD = WORD_W / PIX_WIDTH;
  localparam int unsigned KW           = $clog2(PIX_PER_WORD);
  localparam int unsigned LW           = $clog2(BUF_DEPTH) + 1;

  wr_state_e state, state_next;

  logic [PIX_WIDTH-1:0]      pix_mapped;
  logic [KW-1:0]             pk_cnt;
  logic [KW-1:0]             slot;
  logic [WORD_W-1:0]         pk_word;
  logic [WORD_W-1:0]         word_next;
  logic                      accept;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic [LW-1:0]             level;
  logic [WORD_W-1:0]         fifo_dout;

  logic                      frame_active;
  logic [31:0]               words_in;
  logic                      pend;
  logic                      pend_apply;
  logic [AXI_ADDR_WIDTH-1:0] pend_base;
  logic [AXI_ADDR_WIDTH-1:0] base;
  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [31:0]               beats;
  logic [31:0]               pop_cnt;

`ifdef CHAR_WR_KEY_EN
  // Chroma key applied ahead of the packer, purely combinational
  always_comb pix_mapped = PIX_WIDTH'(key_map(DEF_PIX_WIDTH'(pix_data)));
`else
  // Pixels pass through unmodified
  always_comb pix_mapped = pix_data;
`endif

  assign pix_ready  = ~full;
  assign accept     = pix_valid & pix_ready;
  assign ddr_wreq   = (state == ST_REQ);
  assign ddr_waddr  = base + offset;
  assign ddr_wr_len = LEN_WIDTH'(BURST_LEN);

  // Slot for the incoming pixel; sof restarts at slot 0 and drops any partial word
  always_comb begin
    slot      = pix_sof ? '0 : pk_cnt;
    word_next = pix_sof ? '0 : pk_word;
    word_next[int'(slot)*PIX_WIDTH +: PIX_WIDTH] = pix_mapped;
    push      = accept && (32'(slot) == PIX_PER_WORD - 1);
  end

  // Packer state: pixel count within the word and the partial word itself
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      pk_cnt  <= '0;
      pk_word <= '0;
    end else if (accept) begin
      pk_cnt  <= slot + KW'(1);
      pk_word <= push ? '0 : word_next;
    end
  end

  char_wbuf_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (BUF_DEPTH)
  ) u_wbuf (
    .clk   (ddr_clk),
    .rst   (ddr_rst),
    .push  (push),
    .din   (word_next),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (full)
  );

  // Frame bookkeeping on the pixel side: sof error detection and base capture.
  // A new sof wins over clearing the pending flag in the same cycle.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      sof_err      <= 1'b0;
      frame_active <= 1'b0;
      words_in     <= '0;
      pend         <= 1'b0;
      pend_base    <= '0;
    end else begin
      if (pend_apply)
        pend <= 1'b0;
      if (accept && pix_sof) begin
        if (frame_active && (pk_cnt != '0 || words_in < FRAME_BEATS))
          sof_err <= 1'b1;
        frame_active <= 1'b1;
        words_in     <= '0;
        pend         <= 1'b1;
        pend_base    <= write_BaseDdr_addr;
      end else if (push && words_in < FRAME_BEATS) begin
        words_in <= words_in + 32'd1;
      end
    end
  end

  // Burst engine state register
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Burst engine next state; a pending base takes an IDLE cycle of its own
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    pend_apply = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend)
          pend_apply = 1'b1;
        else if (32'(level) >= BURST_LEN && beats < FRAME_BEATS)
          state_next = ST_REQ;
      end
      ST_REQ: begin
        if (ddr_wrdy)
          state_next = ST_DATA;
      end
      ST_DATA: begin
        if (ddr_wdata_req) begin
          pop = 1'b1;
          if (pop_cnt == BURST_LEN - 1)
            state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ddr_wdone)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/beat counters, beat data register and frame completion pulse
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      base       <= '0;
      offset     <= '0;
      beats      <= '0;
      pop_cnt    <= '0;
      ddr_wdata  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop)
        pop_cnt <= pop_cnt + 32'd1;
      else if (state != ST_DATA)
        pop_cnt <= '0;
      if (pop)
        ddr_wdata <= fifo_dout;
      if (pend_apply) begin
        base   <= pend_base;
        offset <= '0;
        beats  <= '0;
      end
      if (state == ST_WAIT && ddr_wdone) begin
        if (beats + BURST_LEN == FRAME_BEATS) begin
          frame_done <= 1'b1;
          offset     <= '0;
          beats      <= '0;
        end else begin
          offset <= offset + AXI_ADDR_WIDTH'(ADDR_STEP);
          beats  <= beats + BURST_LEN;
        end
      end
    end
  end

endmodule
